// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the RV32M multiply/divide sequencer
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } md_state_e;

    localparam logic [XLEN_DEFAULT-1:0] DIV_ZERO_Q = '1;
    localparam logic [XLEN_DEFAULT-1:0] INT_MIN    = {1'b1, {(XLEN_DEFAULT-1){1'b0}}};

endpackage

// File: rtl/muldiv_unit_div_core.sv
// rtl/muldiv_unit_div_core.sv - restoring radix-2 divider datapath on unsigned magnitudes
module div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            enable,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quoNext,
    output logic [XLEN-1:0] remNext
);

    logic [XLEN-1:0] remReg;
    logic [XLEN-1:0] quoReg;
    logic [XLEN-1:0] divReg;
    logic [XLEN:0]   trial;

    // quoReg doubles as the dividend shifter: its MSB feeds the partial remainder
    // while quotient bits enter at the LSB.
    always_comb begin
        trial = {remReg, quoReg[XLEN-1]} - {1'b0, divReg};
        if (!trial[XLEN]) begin
            remNext = trial[XLEN-1:0];
            quoNext = {quoReg[XLEN-2:0], 1'b1};
        end else begin
            remNext = {remReg[XLEN-2:0], quoReg[XLEN-1]};
            quoNext = {quoReg[XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remReg <= '0;
            quoReg <= '0;
            divReg <= '0;
        end else if (load) begin
            remReg <= '0;
            quoReg <= dividend;
            divReg <= divisor;
        end else if (enable) begin
            remReg <= remNext;
            quoReg <= quoNext;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - EX-stage M-extension sequencer: registered multiply, iterative divide, pipeline stall
module muldiv_unit import muldiv_pkg::*; #(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            kill_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);

    md_state_e         state;
    md_op_e            opReg;
    logic [XLEN-1:0]   aReg;
    logic [XLEN-1:0]   bReg;
    logic [CW-1:0]     cnt;
    logic              negQ;
    logic              negR;

    logic              accept;
    logic              divSigned;
    logic [XLEN-1:0]   absA;
    logic [XLEN-1:0]   absB;
    logic              overflow;
    logic              aSignExt;
    logic              bSignExt;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   quoNext;
    logic [XLEN-1:0]   remNext;
    logic [XLEN-1:0]   divResult;

    assign accept    = start_i & !kill_i & (state == IDLE);
    assign divSigned = !funct3_i[0];
    assign absA      = (divSigned & op_a_i[XLEN-1]) ? -op_a_i : op_a_i;
    assign absB      = (divSigned & op_b_i[XLEN-1]) ? -op_b_i : op_b_i;
    assign overflow  = divSigned & (op_a_i == XLEN'(INT_MIN)) & (op_b_i == '1);

    // Low 2*XLEN bits of the extended product are exact for every sign mix.
    assign aSignExt = ((opReg == OP_MULH) | (opReg == OP_MULHSU)) & aReg[XLEN-1];
    assign bSignExt = (opReg == OP_MULH) & bReg[XLEN-1];
    assign product  = {{XLEN{aSignExt}}, aReg} * {{XLEN{bSignExt}}, bReg};

    assign divResult = opReg[1] ? (negR ? -remNext : remNext)
                                : (negQ ? -quoNext : quoNext);

    div_core #(.XLEN(XLEN)) u_div_core (
        .clk      (clk),
        .rst      (rst),
        .load     (accept & funct3_i[2]),
        .enable   ((state == DIV) & !kill_i),
        .dividend (absA),
        .divisor  (absB),
        .quoNext  (quoNext),
        .remNext  (remNext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            opReg    <= OP_MUL;
            aReg     <= '0;
            bReg     <= '0;
            cnt      <= '0;
            negQ     <= 1'b0;
            negR     <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else if (kill_i) begin
            state  <= IDLE;
            done_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        opReg <= md_op_e'(funct3_i);
                        aReg  <= op_a_i;
                        bReg  <= op_b_i;
                        negQ  <= divSigned & (op_a_i[XLEN-1] ^ op_b_i[XLEN-1]);
                        negR  <= divSigned & op_a_i[XLEN-1];
                        if (!funct3_i[2]) begin
                            state <= MUL;
                        end else if (op_b_i == '0) begin
                            result_o <= funct3_i[1] ? op_a_i : XLEN'(DIV_ZERO_Q);
                            done_o   <= 1'b1;
                            state    <= DONE;
                        end else if (overflow) begin
                            result_o <= funct3_i[1] ? '0 : XLEN'(INT_MIN);
                            done_o   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            cnt   <= CW'(XLEN - 1);
                            state <= DIV;
                        end
                    end
                end
                MUL: begin
                    result_o <= (opReg == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
                    done_o   <= 1'b1;
                    state    <= DONE;
                end
                DIV: begin
                    if (cnt == '0) begin
                        result_o <= divResult;
                        done_o   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o  = (state != IDLE);
    assign stall_o = !rst & !kill_i & (((state == IDLE) & start_i) | (state == MUL) | (state == DIV));

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        kill;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .funct3_i (funct3),
        .op_a_i   (opA),
        .op_b_i   (opB),
        .kill_i   (kill),
        .stall_o  (stall),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa = $signed(a);
        longint      sb = $signed(b);
        longint      ub = {32'b0, b};
        logic [63:0] p;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pickOperand();
        logic [31:0] specials[4] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000};
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return $urandom_range(0, 20);
            2: return specials[$urandom_range(0, 3)];
            default: return -$urandom_range(1, 20);
        endcase
    endfunction

    task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expRes, input int expLat);
        int          lat = -1;
        int          bad = 0;
        logic [31:0] res = '0;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f3; opA = a; opB = b;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stall !== (c < expLat)) bad++;
            if (done) begin
                lat = c;
                res = result;
                break;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'(expLat));
        chk({tag, "_result"}, res, expRes);
        chk({tag, "_stall_bad_cycles"}, bad, 0);
        @(negedge clk);
        chk({tag, "_done_after"}, done, 1'b0);
        chk({tag, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        int doneCnt;

        vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2};
        vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2};
        vecs[2]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2};
        vecs[3]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 2};
        vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       33};
        vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        33};
        vecs[8]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,        32'd0,        32'd5,        1};
        vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1};

        // Reset with start held high: stall must stay masked.
        rst = 1'b1; start = 1'b1; kill = 1'b0; funct3 = 3'd4; opA = 32'd9; opB = 32'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", stall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_result", result, 32'h0);

        foreach (vecs[i])
            runOp($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

        // Kill in cycle 10 of a divide, then a multiply in cycle 11.
        doneCnt = 0;
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd4; opA = 32'd1000; opB = 32'd3;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) doneCnt++;
            @(posedge clk); #1;
            start = 1'b0;
        end
        kill = 1'b1;
        @(negedge clk);
        chk("kill_stall_low", stall, 1'b0);
        if (done) doneCnt++;
        @(posedge clk); #1;
        kill = 1'b0; start = 1'b1; funct3 = 3'd0; opA = 32'd3; opB = 32'd4;
        @(negedge clk);
        chk("kill_idle_busy", busy, 1'b0);
        chk("kill_restart_stall", stall, 1'b1);
        if (done) doneCnt++;
        chk("kill_no_done", doneCnt, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("kill_mul_done_early", done, 1'b0);
        @(negedge clk);
        chk("kill_mul_done", done, 1'b1);
        chk("kill_mul_result", result, 32'd12);

        // Start and kill in the same cycle.
        @(posedge clk); #1;
        start = 1'b1; kill = 1'b1; funct3 = 3'd4; opA = 32'd9; opB = 32'd2;
        @(negedge clk);
        chk("startkill_stall", stall, 1'b0);
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        @(negedge clk);
        chk("startkill_busy", busy, 1'b0);

        // Reset in cycle 5 of a divide clears everything.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd5; opA = 32'd77; opB = 32'd5;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_stall", stall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_stall_after", stall, 1'b0);
        chk("midrst_result", result, 32'h0);

        // start_i held high through DONE: one pulse, no restart.
        doneCnt = 0;
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd0; opA = 32'd5; opB = 32'd6;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) begin
                doneCnt++;
                chk("held_result", result, 32'd30);
            end
            @(posedge clk);
        end
        #1 start = 1'b0;
        @(negedge clk);
        chk("held_no_restart_busy", busy, 1'b0);
        chk("held_no_restart_stall", stall, 1'b0);
        repeat (2) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        chk("held_done_pulses", doneCnt, 1);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] b;
            f3 = 3'($urandom_range(0, 7));
            a  = pickOperand();
            b  = pickOperand();
            runOp($sformatf("rnd%0d_f%0d_%0h_%0h", i, f3, a, b), f3, a, b, refModel(f3, a, b), refLatency(f3, a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
